row_buffer_writer_rr: RTL and testbench

ROW_BUFFER_WRITER_RR -- requirements
Module: row_buffer_writer_rr

---
 rtl/row_buffer_writer_rr_if.sv | 32 +++
 rtl/row_buffer_writer_rr.sv | 163 ++++++++++++++++
 tb/tb_row_buffer_writer_rr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/row_buffer_writer_rr_if.sv
// Beat-in / bank-write-out bus for the round-robin row buffer writer.
// master = frame source side, slave = writer block.
interface row_buffer_writer_rr_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IW         = 7,
    parameter int WH         = 2,
    parameter int BANKS      = 4,
    parameter int ADDR_WIDTH = 16
);
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                               start;
    logic [BW-1:0]                      start_bank;
    logic                               in_valid;
    logic                               in_ready;
    logic [WH*IW*DATA_WIDTH-1:0]        in_data;
    logic [BANKS-1:0]                   wr_en;
    logic [BANKS*ADDR_WIDTH-1:0]        wr_addr;
    logic [BANKS*IW*DATA_WIDTH-1:0]     wr_data;
    logic                               busy;
    logic                               done;

    modport master (
        output start, start_bank, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, start_bank, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/row_buffer_writer_rr.sv
// Scatters WH-row input beats across BANKS row-buffer RAMs in round-robin
// order starting at start_bank; each bank addresses its own writes from 0.

module row_buffer_writer_rr_bank #(
    parameter int WORD_W     = 56,
    parameter int WH         = 2,
    parameter int BANKS      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int BANK_ID    = 0,
    parameter int BW         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       fire,
    input  logic [BW-1:0]              base,
    input  logic [BW:0]                nrows,
    input  logic [WH-1:0][WORD_W-1:0]  rows,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [WORD_W-1:0]          wr_data
);
    localparam logic [BW:0] ID = (BW+1)'(BANK_ID);
    localparam logic [BW:0] NB = (BW+1)'(BANKS);

    logic [BW:0]           off;
    logic                  hit;
    logic [WORD_W-1:0]     word;
    logic [ADDR_WIDTH-1:0] cnt;

    // Slot within the current beat that lands on this bank: (ID - base) mod BANKS.
    // WH <= BANKS guarantees at most one slot per bank per beat.
    always_comb begin
        off  = (ID >= {1'b0, base}) ? ID - {1'b0, base} : ID + NB - {1'b0, base};
        hit  = fire && (off < nrows);
        word = '0;
        for (int r = 0; r < WH; r++)
            if (off == (BW+1)'(r)) word = rows[r];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= hit;
            wr_data <= hit ? word : '0;
            if (clr) begin
                cnt <= '0;
            end else if (hit) begin
                wr_addr <= cnt;
                cnt     <= cnt + 1'b1;
            end
        end
    end
endmodule

module row_buffer_writer_rr #(
    parameter int DATA_WIDTH = 8,
    parameter int IW         = 7,
    parameter int WH         = 2,
    parameter int BANKS      = 4,
    parameter int ROWS       = 9,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    row_buffer_writer_rr_if.slave bus
);
    localparam int BW     = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int WORD_W = IW * DATA_WIDTH;
    localparam int BEATS  = (ROWS + WH - 1) / WH;
    localparam int KW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);
    localparam logic [BW:0]   WH_N   = (BW+1)'(WH);
    localparam logic [BW:0]   LAST_N = (BW+1)'(ROWS - (BEATS - 1) * WH);
    localparam logic [BW:0]   NB     = (BW+1)'(BANKS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [KW-1:0] beat;
    logic [BW-1:0] base;
    logic [BW-1:0] base_nxt;
    logic [BW:0]   base_sum;
    logic [BW:0]   nrows;
    logic          start_acc;
    logic          fire;
    logic          last;

    logic [WH-1:0][WORD_W-1:0]        rows;
    logic [BANKS-1:0]                 en_v;
    logic [BANKS-1:0][ADDR_WIDTH-1:0] addr_v;
    logic [BANKS-1:0][WORD_W-1:0]     data_v;

    assign rows         = bus.in_data;
    assign bus.wr_en    = en_v;
    assign bus.wr_addr  = addr_v;
    assign bus.wr_data  = data_v;
    assign bus.in_ready = (state == S_RUN);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);

    assign start_acc = (state == S_IDLE) && bus.start;
    assign fire      = (state == S_RUN) && bus.in_valid;
    assign last      = (beat == LAST_K);
    assign nrows     = last ? LAST_N : WH_N;

    // Rotate the base bank by WH per beat; one conditional subtract suffices.
    assign base_sum = {1'b0, base} + WH_N;
    assign base_nxt = BW'((base_sum >= NB) ? base_sum - NB : base_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            beat  <= '0;
            base  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_acc) begin
                    state <= S_RUN;
                    beat  <= '0;
                    base  <= bus.start_bank;
                end
                S_RUN: if (fire) begin
                    base <= base_nxt;
                    if (last) state <= S_FLUSH;
                    else      beat  <= beat + 1'b1;
                end
                S_FLUSH: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        row_buffer_writer_rr_bank #(
            .WORD_W     (WORD_W),
            .WH         (WH),
            .BANKS      (BANKS),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BANK_ID    (b),
            .BW         (BW)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .clr     (start_acc),
            .fire    (fire),
            .base    (base),
            .nrows   (nrows),
            .rows    (rows),
            .wr_en   (en_v[b]),
            .wr_addr (addr_v[b]),
            .wr_data (data_v[b])
        );
    end
endmodule

// File: tb/tb_row_buffer_writer_rr.sv
// Bench for row_buffer_writer_rr: vector table, directed corner sequences and
// random-gap frames against a row-level reference model.
module tb_row_buffer_writer_rr;
    localparam int DW = 8, IW = 7, WH = 2, BANKS = 4, ROWS = 9, AW = 16;
    localparam int WORD = DW * IW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_buffer_writer_rr_if #(.DATA_WIDTH(DW), .IW(IW), .WH(WH), .BANKS(BANKS), .ADDR_WIDTH(AW)) bus ();
    row_buffer_writer_rr_if #(.DATA_WIDTH(DW), .IW(IW), .WH(WH), .BANKS(BANKS), .ADDR_WIDTH(AW)) bus8 ();

    row_buffer_writer_rr #(.DATA_WIDTH(DW), .IW(IW), .WH(WH), .BANKS(BANKS), .ROWS(ROWS), .ADDR_WIDTH(AW))
        dut (.clk(clk), .rst(rst), .bus(bus));
    row_buffer_writer_rr #(.DATA_WIDTH(DW), .IW(IW), .WH(WH), .BANKS(BANKS), .ROWS(8), .ADDR_WIDTH(AW))
        dut8 (.clk(clk), .rst(rst), .bus(bus8));

    logic [WH-1:0][WORD-1:0] tb_rows;
    assign bus.in_data  = tb_rows;
    assign bus8.in_data = tb_rows;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: tracks frame rows, not FSM encoding.
    bit                          m_run;
    int                          m_n, m_sb, m_tail;
    logic [BANKS-1:0]            e_en;
    logic [BANKS-1:0][AW-1:0]    e_addr;
    logic [BANKS-1:0][WORD-1:0]  e_data;

    typedef struct {
        logic        start;
        logic [1:0]  sb;
        logic        valid;
        logic [3:0]  en;
        logic [63:0] addr;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int n, b;
        e_en   = '0;
        e_data = '0;
        if (rst) begin
            m_run = 0; m_tail = 0; m_n = 0; e_addr = '0;
            return;
        end
        if (m_tail == 1) m_tail = 2;
        else if (m_tail == 2) m_tail = 0;
        else if (!m_run) begin
            if (bus.start) begin
                m_run = 1; m_sb = int'(bus.start_bank); m_n = 0;
            end
        end else if (bus.in_valid) begin
            for (int r = 0; r < WH; r++) begin
                n = m_n + r;
                if (n < ROWS) begin
                    b = (m_sb + n) % BANKS;
                    e_en[b]   = 1'b1;
                    e_addr[b] = AW'(n / BANKS);
                    e_data[b] = tb_rows[r];
                end
            end
            m_n += WH;
            if (m_n >= ROWS) begin m_run = 0; m_tail = 1; end
        end
    endtask

    task automatic check_all();
        chk("in_ready", bus.in_ready, m_run);
        chk("busy",     bus.busy,     m_run || (m_tail != 0));
        chk("done",     bus.done,     m_tail == 2);
        chk("wr_en",    bus.wr_en,    e_en);
        chk("wr_addr",  bus.wr_addr,  e_addr);
        chk("wr_data",  bus.wr_data,  e_data);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_rows();
        for (int r = 0; r < WH; r++)
            for (int j = 0; j < IW; j++)
                tb_rows[r][j*DW +: DW] = 8'($urandom);
    endtask

    task automatic drain();
        bus.in_valid = 1'b0; bus.start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{1'b1, 2'd0, 1'b0, 4'b0000, 64'h0, 1'b1, 1'b0};
        tv[1] = '{1'b0, 2'd0, 1'b1, 4'b0011, 64'h0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 2'd0, 1'b1, 4'b1100, 64'h0, 1'b1, 1'b0};
        tv[3] = '{1'b0, 2'd0, 1'b1, 4'b0011, {16'd0, 16'd0, 16'd1, 16'd1}, 1'b1, 1'b0};
        tv[4] = '{1'b0, 2'd0, 1'b1, 4'b1100, {16'd1, 16'd1, 16'd1, 16'd1}, 1'b1, 1'b0};
        tv[5] = '{1'b0, 2'd0, 1'b1, 4'b0001, {16'd1, 16'd1, 16'd1, 16'd2}, 1'b1, 1'b0};
        tv[6] = '{1'b0, 2'd0, 1'b0, 4'b0000, {16'd1, 16'd1, 16'd1, 16'd2}, 1'b1, 1'b1};
        tv[7] = '{1'b0, 2'd0, 1'b0, 4'b0000, {16'd1, 16'd1, 16'd1, 16'd2}, 1'b0, 1'b0};

        bus.start = 1'b0; bus.start_bank = '0; bus.in_valid = 1'b0;
        bus8.start = 1'b0; bus8.start_bank = '0; bus8.in_valid = 1'b0;
        tb_rows = '0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_wr_en", bus.wr_en, 4'b0);
        rst = 1'b0;
        tick();

        // Back-to-back frame, start_bank=0
        for (int i = 0; i < 8; i++) begin
            bus.start = tv[i].start; bus.start_bank = tv[i].sb; bus.in_valid = tv[i].valid;
            rand_rows();
            tick();
            chk($sformatf("tv%0d_en", i),   bus.wr_en,   tv[i].en);
            chk($sformatf("tv%0d_addr", i), bus.wr_addr, tv[i].addr);
            chk($sformatf("tv%0d_busy", i), bus.busy,    tv[i].busy);
            chk($sformatf("tv%0d_done", i), bus.done,    tv[i].done);
        end

        // start_bank=3: wrap across bank 3 -> bank 0
        bus.start = 1'b1; bus.start_bank = 2'd3; tick();
        bus.start = 1'b0; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_rows(); tick();
            if (k == 0) begin
                chk("sb3_b0_en",    bus.wr_en, 4'b1001);
                chk("sb3_b0_addr3", bus.wr_addr[3*AW +: AW], 16'd0);
                chk("sb3_b0_addr0", bus.wr_addr[0 +: AW], 16'd0);
            end
        end
        chk("sb3_b4_en",    bus.wr_en, 4'b1000);
        chk("sb3_b4_addr3", bus.wr_addr[3*AW +: AW], 16'd2);
        drain();

        // Random frames with gaps, stray starts in RUN, in_valid held in IDLE
        for (int f = 0; f < 8; f++) begin
            int guard;
            bus.start = 1'b1; bus.start_bank = 2'($urandom_range(0, 3)); bus.in_valid = 1'b0;
            tick();
            bus.start = 1'b0;
            guard = 0;
            while (m_run && guard < 100) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.start = ($urandom_range(0, 3) == 0);
                    bus.start_bank = 2'($urandom_range(0, 3));
                    bus.in_valid = 1'b0;
                    tick();
                end
                bus.start = 1'b0; bus.in_valid = 1'b1; rand_rows();
                tick();
                bus.in_valid = 1'b0;
                guard++;
            end
            chk("frame_timeout", guard >= 100, 1'b0);
            bus.in_valid = 1'b1;
            repeat (4) tick();
            bus.in_valid = 1'b0;
            tick();
        end

        // Reset mid-frame after beat 2, then a clean frame
        bus.start = 1'b1; bus.start_bank = 2'd1; tick();
        bus.start = 1'b0; bus.in_valid = 1'b1;
        repeat (3) begin rand_rows(); tick(); end
        bus.in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("abort_en",   bus.wr_en, 4'b0);
        chk("abort_busy", bus.busy,  1'b0);
        chk("abort_addr", bus.wr_addr, 64'h0);
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("abort_no_done", bus.done, 1'b0);
        end
        bus.start = 1'b1; bus.start_bank = 2'd2; tick();
        bus.start = 1'b0; bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rand_rows(); tick();
            if (k == 0) begin
                chk("post_rst_en",    bus.wr_en, 4'b1100);
                chk("post_rst_addr2", bus.wr_addr[2*AW +: AW], 16'd0);
                chk("post_rst_addr3", bus.wr_addr[3*AW +: AW], 16'd0);
            end
        end
        drain();

        // ROWS=8 instance: four full beats
        bus8.start = 1'b1; bus8.start_bank = 2'd0; tick();
        bus8.start = 1'b0; bus8.in_valid = 1'b1;
        repeat (4) begin rand_rows(); tick(); end
        bus8.in_valid = 1'b0;
        chk("r8_final_en",   bus8.wr_en, 4'b1100);
        chk("r8_final_addr", bus8.wr_addr, {16'd1, 16'd1, 16'd1, 16'd1});
        chk("r8_flush_done", bus8.done, 1'b0);
        chk("r8_flush_rdy",  bus8.in_ready, 1'b0);
        tick();
        chk("r8_done",       bus8.done, 1'b1);
        chk("r8_done_en",    bus8.wr_en, 4'b0);
        tick();
        chk("r8_idle_busy",  bus8.busy, 1'b0);
        chk("r8_idle_done",  bus8.done, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
